// File: rtl/if_fetch_stage_pkg.sv
// if_pkg: next-PC select encodings, exception vectors and bubble word for the fetch stage
package if_pkg;
    typedef enum logic [2:0] {
        PC_SEL_SEQ    = 3'd0,
        PC_SEL_BRANCH = 3'd1,
        PC_SEL_JUMP   = 3'd2,
        PC_SEL_JR     = 3'd3,
        PC_SEL_ILLOP  = 3'd4,
        PC_SEL_XADR   = 3'd5
    } pc_sel_e;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
    localparam logic [31:0] XADR_PC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    // Branch/jump targets cannot change privilege: bit31 comes from the current PC
    function automatic logic [31:0] keep_mode(input logic [31:0] pc, input logic [31:0] tgt);
        return (tgt & 32'h7FFF_FFFF) | (pc & 32'h8000_0000);
    endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: control, ROM and IF/ID bundle of the fetch stage; IF_PERF_CNT_EN adds counter outputs
interface if_fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [2:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif
    modport master (
        output stall, flush, pc_sel, branch_target, jump_target, jr_target, rom_data,
        input  rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid
`ifdef IF_PERF_CNT_EN
        , input fetch_count, stall_count
`endif
    );
    modport slave (
        input  stall, flush, pc_sel, branch_target, jump_target, jr_target, rom_data,
        output rom_addr, pc, if_id_instr, if_id_pc_plus4, if_id_valid
`ifdef IF_PERF_CNT_EN
        , output fetch_count, stall_count
`endif
    );
endinterface

// File: rtl/if_fetch_stage_pc_mux.sv
// if_pc_mux: combinational next-PC select with supervisor-bit rules
module if_pc_mux
    import if_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic [31:0] pc_i,
    input  logic [2:0]  pc_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);
    assign pc_plus4_o = {pc_i[31], pc_i[30:0] + 31'd4};
    assign redirect_o = (pc_sel_i != PC_SEL_SEQ) && (pc_sel_i <= PC_SEL_XADR);
    // jr is taken verbatim: it is the only way back to user mode
    assign next_pc_o = (pc_sel_i == PC_SEL_ILLOP)  ? ILLOP_VEC :
                       (pc_sel_i == PC_SEL_XADR)   ? XADR_VEC :
                       (pc_sel_i == PC_SEL_BRANCH) ? keep_mode(pc_i, branch_target_i) :
                       (pc_sel_i == PC_SEL_JUMP)   ? keep_mode(pc_i, jump_target_i) :
                       (pc_sel_i == PC_SEL_JR)     ? jr_target_i : pc_plus4_o;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, ROM addressing and IF/ID register; IF_PERF_CNT_EN adds fetch/stall counters
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = if_pkg::RESET_PC,
    parameter logic [31:0] ILLOP_PC  = if_pkg::ILLOP_PC,
    parameter logic [31:0] XADR_PC   = if_pkg::XADR_PC,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input logic              clk,
    input logic              rst_n,
    if_fetch_stage_if.slave  fetch_if
);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc_plus4, next_pc;
    logic        valid_q, valid_d, redirect;
    if_pc_mux #(.ILLOP_VEC(ILLOP_PC), .XADR_VEC(XADR_PC)) u_pc_mux (
        .pc_i           (pc_q),
        .pc_sel_i       (fetch_if.pc_sel),
        .branch_target_i(fetch_if.branch_target),
        .jump_target_i  (fetch_if.jump_target),
        .jr_target_i    (fetch_if.jr_target),
        .pc_plus4_o     (pc_plus4),
        .next_pc_o      (next_pc),
        .redirect_o     (redirect)
    );
    // Redirects override stall; flush overrides stall so a bubble is never held
    always_comb begin
        pc_d    = (redirect || !fetch_if.stall) ? next_pc : pc_q;
        instr_d = fetch_if.flush ? NOP_INSTR : fetch_if.stall ? instr_q : fetch_if.rom_data;
        pc4_d   = (fetch_if.flush || !fetch_if.stall) ? pc_plus4 : pc4_q;
        valid_d = fetch_if.flush ? 1'b0 : fetch_if.stall ? valid_q : 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end
    assign fetch_if.rom_addr       = {pc_q[31:2], 2'b00};
    assign fetch_if.pc             = pc_q;
    assign fetch_if.if_id_instr    = instr_q;
    assign fetch_if.if_id_pc_plus4 = pc4_q;
    assign fetch_if.if_id_valid    = valid_q;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, !fetch_if.flush && !fetch_if.stall};
        stall_cnt_d = stall_cnt_q + {31'd0, fetch_if.stall && !fetch_if.flush};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign fetch_if.fetch_count = fetch_cnt_q;
    assign fetch_if.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and randomized checks of if_fetch_stage against a behavioural fetch model
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    if_fetch_stage_if bus();
    if_fetch_stage dut (.clk(clk), .rst_n(rst_n), .fetch_if(bus.slave));
    logic [31:0] rom [64];
    assign bus.rom_data = rom[bus.rom_addr[7:2]];
    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_instr = 32'h0; m_pc4 = 32'h8000_0000; m_valid = 1'b0; m_fc = 0; m_sc = 0;
    endtask

    // One clock of stimulus; the model advances from the architectural rules
    task automatic cycle(input logic st, input logic fl, input logic [2:0] sel,
                         input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        logic [31:0] p4;
        bus.stall = st; bus.flush = fl; bus.pc_sel = sel;
        bus.branch_target = bt; bus.jump_target = jt; bus.jr_target = jrt;
        @(posedge clk);
        p4 = {m_pc[31], m_pc[30:0] + 31'd4};
        if (fl) begin
            m_instr = 32'h0; m_valid = 1'b0; m_pc4 = p4;
        end else if (!st) begin
            m_instr = rom[m_pc[7:2]]; m_valid = 1'b1; m_pc4 = p4; m_fc = m_fc + 1;
        end
        if (st && !fl) m_sc = m_sc + 1;
        case (sel)
            3'd1: m_pc = {m_pc[31], bt[30:0]};
            3'd2: m_pc = {m_pc[31], jt[30:0]};
            3'd3: m_pc = jrt;
            3'd4: m_pc = 32'h8000_0004;
            3'd5: m_pc = 32'h8000_0008;
            default: if (!st) m_pc = p4;
        endcase
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0005;
        cycle(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp 80000000", bus.pc); end
        checks++; if (bus.rom_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_rom_addr got %h exp 80000000", bus.rom_addr); end
        checks++; if (bus.if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", bus.if_id_instr); end
        checks++; if (bus.if_id_pc_plus4 !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc4 got %h exp 80000000", bus.if_id_pc_plus4); end
        checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.if_id_instr !== 32'h2008_0005) begin errors++; $display("FAIL first_instr got %h exp 20080005", bus.if_id_instr); end
        checks++; if (bus.if_id_pc_plus4 !== 32'h8000_0004) begin errors++; $display("FAIL first_pc4 got %h exp 80000004", bus.if_id_pc_plus4); end
        checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", bus.if_id_valid); end
        checks++; if (bus.pc !== 32'h8000_0004) begin errors++; $display("FAIL first_pc got %h exp 80000004", bus.pc); end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0008) begin errors++; $display("FAIL seq_pc got %h exp 80000008", bus.pc); end
        checks++; if (bus.if_id_instr !== rom[1]) begin errors++; $display("FAIL seq_instr got %h exp %h", bus.if_id_instr, rom[1]); end
    endtask

    task automatic test_stall();
        repeat (2) begin
            cycle(1, 0, 0, 0, 0, 0);
            checks++; if (bus.pc !== 32'h8000_0008) begin errors++; $display("FAIL stall_pc got %h exp 80000008", bus.pc); end
            checks++; if (bus.if_id_instr !== rom[1] || bus.if_id_pc_plus4 !== 32'h8000_0008 || bus.if_id_valid !== 1'b1)
                begin errors++; $display("FAIL stall_ifid got %h/%h/%b exp %h/80000008/1", bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid, rom[1]); end
        end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_000C) begin errors++; $display("FAIL resume_pc got %h exp 8000000c", bus.pc); end
        checks++; if (bus.if_id_instr !== rom[2] || bus.if_id_pc_plus4 !== 32'h8000_000C)
            begin errors++; $display("FAIL resume_ifid got %h/%h exp %h/8000000c", bus.if_id_instr, bus.if_id_pc_plus4, rom[2]); end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.if_id_instr !== rom[3]) begin errors++; $display("FAIL resume2_instr got %h exp %h", bus.if_id_instr, rom[3]); end
    endtask

    task automatic test_branch_flush();
        cycle(1, 1, 1, 32'h0000_0040, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0040) begin errors++; $display("FAIL branch_pc got %h exp 80000040", bus.pc); end
        checks++; if (bus.if_id_instr !== 32'h0 || bus.if_id_valid !== 1'b0)
            begin errors++; $display("FAIL flush_ifid got %h/%b exp 00000000/0", bus.if_id_instr, bus.if_id_valid); end
        checks++; if (bus.if_id_pc_plus4 !== 32'h8000_0014) begin errors++; $display("FAIL flush_pc4 got %h exp 80000014", bus.if_id_pc_plus4); end
    endtask

    task automatic test_exception_jr();
        cycle(0, 0, 3, 0, 0, 32'h0000_0100);
        checks++; if (bus.pc !== 32'h0000_0100) begin errors++; $display("FAIL jr_user_pc got %h exp 00000100", bus.pc); end
        cycle(0, 0, 2, 0, 32'hFFFF_0200, 0);
        checks++; if (bus.pc !== 32'h7FFF_0200) begin errors++; $display("FAIL jump_user_pc got %h exp 7fff0200", bus.pc); end
        cycle(0, 0, 3, 0, 0, 32'h0000_0100);
        cycle(1, 0, 5, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0008) begin errors++; $display("FAIL xadr_pc got %h exp 80000008", bus.pc); end
        cycle(0, 0, 3, 0, 0, 32'h0000_0104);
        checks++; if (bus.pc !== 32'h0000_0104) begin errors++; $display("FAIL jr_pc got %h exp 00000104", bus.pc); end
        cycle(1, 0, 4, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0004) begin errors++; $display("FAIL illop_pc got %h exp 80000004", bus.pc); end
        cycle(0, 0, 6, 32'h0000_0400, 32'h0000_0400, 32'h0000_0400);
        checks++; if (bus.pc !== 32'h8000_0008) begin errors++; $display("FAIL sel6_pc got %h exp 80000008", bus.pc); end
        cycle(0, 0, 3, 0, 0, 32'h0000_0103);
        checks++; if (bus.pc !== 32'h0000_0103 || bus.rom_addr !== 32'h0000_0100)
            begin errors++; $display("FAIL unaligned got %h/%h exp 00000103/00000100", bus.pc, bus.rom_addr); end
        cycle(0, 0, 3, 0, 0, 32'h7FFF_FFFC);
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pc !== 32'h0000_0000) begin errors++; $display("FAIL user_wrap got %h exp 00000000", bus.pc); end
        cycle(0, 0, 3, 0, 0, 32'hFFFF_FFFC);
        cycle(0, 0, 7, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL kernel_wrap got %h exp 80000000", bus.pc); end
    endtask

    task automatic test_random();
        logic [2:0] sel;
        for (int n = 0; n < 400; n++) begin
            sel = 3'($urandom_range(0, 11) > 7 ? 0 : $urandom_range(0, 7));
            cycle(($urandom % 4) == 0, ($urandom % 5) == 0, sel, $urandom, $urandom, $urandom);
            checks++; if (bus.pc !== m_pc || bus.rom_addr !== {m_pc[31:2], 2'b00})
                begin errors++; $display("FAIL rnd_pc n=%0d got %h/%h exp %h", n, bus.pc, bus.rom_addr, m_pc); end
            checks++; if (bus.if_id_instr !== m_instr || bus.if_id_pc_plus4 !== m_pc4 || bus.if_id_valid !== m_valid)
                begin errors++; $display("FAIL rnd_ifid n=%0d got %h/%h/%b exp %h/%h/%b", n, bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid, m_instr, m_pc4, m_valid); end
`ifdef IF_PERF_CNT_EN
            checks++; if (bus.fetch_count !== m_fc || bus.stall_count !== m_sc)
                begin errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d exp %0d/%0d", n, bus.fetch_count, bus.stall_count, m_fc, m_sc); end
`endif
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 3, 0, 0, 32'h8000_0020);
        @(negedge clk);
        bus.stall = 1'b1; bus.pc_sel = 3'd1; bus.branch_target = 32'h0000_0300;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.pc !== 32'h8000_0000 || bus.if_id_instr !== 32'h0 || bus.if_id_pc_plus4 !== 32'h8000_0000 || bus.if_id_valid !== 1'b0)
            begin errors++; $display("FAIL async_reset got %h/%h/%h/%b", bus.pc, bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid); end
`ifdef IF_PERF_CNT_EN
        checks++; if (bus.fetch_count !== 32'd0 || bus.stall_count !== 32'd0)
            begin errors++; $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", bus.fetch_count, bus.stall_count); end
`endif
        @(negedge clk) rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (bus.pc !== 32'h8000_0004 || bus.if_id_instr !== 32'h2008_0005)
            begin errors++; $display("FAIL post_reset got %h/%h exp 80000004/20080005", bus.pc, bus.if_id_instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_flush();
        test_exception_jr();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
